// File: rtl/adc_iq_sequencer.sv
// adc_iq_sequencer: paces I/Q sample-pair acquisition from a shared ADC
// controller at f_clk/DIV, always converting I before Q, and republishes
// each result as a 10-bit offset-binary sample (en/channel/X). Missed pair
// ticks and response timeouts are reported through sticky flags.
//
// Handshakes: a command transfers on every rising clk edge where
// cmd_valid && cmd_ready; cmd_valid and cmd_channel hold steady from the
// first cycle they assert until that transfer. rsp_valid is a single-cycle
// strobe with no backpressure; it is only looked at in the WAIT states and
// only when rsp_channel names the channel being waited for.
module adc_iq_sequencer #(
  parameter int         DIV     = 200,
  parameter int         TIMEOUT = 64,
  parameter logic [2:0] CH_I    = 3'd6,
  parameter logic [2:0] CH_Q    = 3'd4,
  parameter int         ADC_W   = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [4:0]       cmd_channel,
  input  logic             rsp_valid,
  input  logic [4:0]       rsp_channel,
  input  logic [ADC_W-1:0] rsp_data,
  output logic             en,
  output logic [2:0]       channel,
  output logic [9:0]       X,
  output logic             overrun,
  output logic             timeout_err,
  input  logic             clr_err,
  output logic [2:0]       fsm_state_o
);

  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD_I  = 3'd1,
    S_WAIT_I = 3'd2,
    S_CMD_Q  = 3'd3,
    S_WAIT_Q = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rate_q, rate_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [4:0]    cmd_channel_q, cmd_channel_d;
  logic          en_q, en_d;
  logic [2:0]    channel_q, channel_d;
  logic [9:0]    x_q, x_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic tick;
  logic match_i;
  logic match_q;
  logic capture;
  logic [2:0] capture_ch;
  logic to_set;
  logic ov_set;

  // Only the top 10 bits of the ADC result are used; the rest are dropped.
  if (ADC_W > 10) begin : g_lsb
    logic unused_rsp_lsbs;
    assign unused_rsp_lsbs = ^rsp_data[ADC_W-11:0];
  end

  assign tick    = run && (rate_q == CW'(DIV - 1));
  assign match_i = rsp_valid && (rsp_channel == {2'b00, CH_I});
  assign match_q = rsp_valid && (rsp_channel == {2'b00, CH_Q});

  // Pair-rate counter: free-runs 0..DIV-1 while run is high, parked at 0 otherwise.
  always_comb begin
    rate_d = rate_q;
    if (!run || tick) rate_d = '0;
    else              rate_d = rate_q + CW'(1);
  end

  // Next-state logic, response matching, timeout and output staging.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    capture    = 1'b0;
    capture_ch = CH_I;
    to_set     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_CMD_I;
      end
      S_CMD_I: begin
        if (cmd_ready) begin
          state_d = S_WAIT_I;
          tcnt_d  = '0;
        end
      end
      S_WAIT_I: begin
        if (match_i) begin
          capture    = 1'b1;
          capture_ch = CH_I;
          state_d    = S_CMD_Q;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          to_set  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_CMD_Q: begin
        if (cmd_ready) begin
          state_d = S_WAIT_Q;
          tcnt_d  = '0;
        end
      end
      S_WAIT_Q: begin
        if (match_q) begin
          capture    = 1'b1;
          capture_ch = CH_Q;
          state_d    = S_IDLE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // I has already gone out for this pair; downstream copes with a lone I.
          to_set  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A tick that finds a pair still in flight is dropped, not queued.
    ov_set = tick && (state_q != S_IDLE);

    cmd_valid_d   = (state_d == S_CMD_I) || (state_d == S_CMD_Q);
    cmd_channel_d = 5'd0;
    if (state_d == S_CMD_I) cmd_channel_d = {2'b00, CH_I};
    if (state_d == S_CMD_Q) cmd_channel_d = {2'b00, CH_Q};

    en_d      = capture;
    channel_d = channel_q;
    x_d       = x_q;
    if (capture) begin
      channel_d = capture_ch;
      x_d       = rsp_data[ADC_W-1 -: 10];
    end

    // Set beats clear when both land in the same cycle.
    overrun_d = ov_set || (overrun_q && !clr_err);
    timeout_d = to_set || (timeout_q && !clr_err);
  end

  // State and output registers; async reset returns everything to idle at midscale.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      rate_q        <= '0;
      tcnt_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_channel_q <= 5'd0;
      en_q          <= 1'b0;
      channel_q     <= 3'd0;
      x_q           <= 10'd512;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      tcnt_q        <= tcnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_channel_q <= cmd_channel_d;
      en_q          <= en_d;
      channel_q     <= channel_d;
      x_q           <= x_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_channel = cmd_channel_q;
  assign en          = en_q;
  assign channel     = channel_q;
  assign X           = x_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_adc_iq_sequencer.sv
// tb_adc_iq_sequencer: drives adc_iq_sequencer with a reactive ADC controller
// model and compares every cycle against a transaction-level reference that
// tracks the pair schedule with plain counters, plus directed literal checks.
module tb_adc_iq_sequencer;
  localparam int         DIV     = 8;
  localparam int         TIMEOUT = 4;
  localparam logic [2:0] CH_I    = 3'd6;
  localparam logic [2:0] CH_Q    = 3'd4;
  localparam int         ADC_W   = 12;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             run = 1'b0;
  logic             cmd_ready = 1'b0;
  logic             rsp_valid = 1'b0;
  logic [4:0]       rsp_channel = 5'd0;
  logic [ADC_W-1:0] rsp_data = '0;
  logic             clr_err = 1'b0;
  logic             cmd_valid;
  logic [4:0]       cmd_channel;
  logic             en;
  logic [2:0]       channel;
  logic [9:0]       X;
  logic             overrun;
  logic             timeout_err;
  logic [2:0]       fsm_state;

  adc_iq_sequencer #(
    .DIV(DIV), .TIMEOUT(TIMEOUT), .CH_I(CH_I), .CH_Q(CH_Q), .ADC_W(ADC_W)
  ) dut (
    .clk(clk), .rstn(rstn), .run(run),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_channel(cmd_channel),
    .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .en(en), .channel(channel), .X(X),
    .overrun(overrun), .timeout_err(timeout_err), .clr_err(clr_err),
    .fsm_state_o(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] ch_of(input int i);
    return (i == 0) ? CH_I : CH_Q;
  endfunction

  // ---------------- controller model knobs ----------------
  int dly_i = 2, dly_q = 2;
  bit drop_q = 0, wrong_first = 0, noise_en = 0, rand_ready = 0, hold_ready = 0;
  bit fixed_data = 1, rand_dly = 0;

  int cyc = 0;
  int hs_cnt = 0;
  int pd;
  int pend_due[$];
  logic [4:0] pend_ch[$];

  // Edge bookkeeping: count cycles, record handshakes, schedule responses.
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      pend_due.delete();
      pend_ch.delete();
    end else if (cmd_valid && cmd_ready) begin
      hs_cnt++;
      if (!(drop_q && cmd_channel == {2'b00, CH_Q})) begin
        if (rand_dly) pd = $urandom_range(1, 6);
        else          pd = (cmd_channel == {2'b00, CH_I}) ? dly_i : dly_q;
        pend_due.push_back(cyc + pd);
        pend_ch.push_back(cmd_channel);
      end
    end
  end

  // Controller driver: cmd_ready policy and response/noise injection.
  bit found;
  always @(negedge clk) begin
    rsp_valid   = 1'b0;
    rsp_channel = 5'($urandom_range(0, 31));
    rsp_data    = ADC_W'($urandom);
    found = 0;
    if (!rstn) begin
      pend_due.delete();
      pend_ch.delete();
    end
    for (int i = 0; i < pend_due.size(); i++) begin
      if (pend_due[i] == cyc + 1) begin
        found       = 1;
        rsp_valid   = 1'b1;
        rsp_channel = pend_ch[i];
        if (fixed_data) rsp_data = (pend_ch[i] == {2'b00, CH_I}) ? 12'hA00 : 12'h3FF;
        pend_due.delete(i);
        pend_ch.delete(i);
        break;
      end
    end
    while (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      pend_due.pop_front();
      pend_ch.pop_front();
    end
    if (!found && wrong_first) begin
      for (int i = 0; i < pend_due.size(); i++) begin
        if (pend_due[i] == cyc + 2) begin
          found       = 1;
          rsp_valid   = 1'b1;
          rsp_channel = 5'd5;
          rsp_data    = 12'h111;
        end
      end
    end
    if (!found && noise_en && $urandom_range(0, 5) == 0) begin
      rsp_valid = 1'b1;
      case ($urandom_range(0, 3))
        0: rsp_channel = {2'b00, CH_I};
        1: rsp_channel = {2'b00, CH_Q};
        2: rsp_channel = 5'd5;
        default: rsp_channel = 5'($urandom_range(0, 31));
      endcase
    end
    if (hold_ready)      cmd_ready = 1'b0;
    else if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    else                 cmd_ready = 1'b1;
  end

  // ---------------- reference model ----------------
  // Schedule-level view: m_rate is the cycle position within the pair
  // period, m_phase 0=no pair,1=asking,2=awaiting result, m_idx 0=I 1=Q,
  // m_w is the number of cycles already spent awaiting.
  int m_rate, m_phase, m_idx, m_w;
  bit m_tick, m_set_ov, m_set_to;
  logic m_cmd_valid, m_en, m_ov, m_to;
  logic [4:0] m_cmd_ch;
  logic [2:0] m_ch;
  logic [9:0] m_x;
  logic [12:0] exp_q[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rate = 0; m_phase = 0; m_idx = 0; m_w = 0;
      m_cmd_valid = 0; m_cmd_ch = 0; m_en = 0; m_ch = 0; m_x = 10'd512;
      m_ov = 0; m_to = 0;
      exp_q.delete();
    end else begin
      m_tick   = run && (m_rate == DIV - 1);
      m_rate   = (!run || m_tick) ? 0 : m_rate + 1;
      m_set_ov = m_tick && (m_phase != 0);
      m_set_to = 0;
      m_en     = 0;
      case (m_phase)
        0: if (m_tick) begin m_phase = 1; m_idx = 0; end
        1: if (cmd_ready) begin m_phase = 2; m_w = 0; end
        default: begin
          if (rsp_valid && rsp_channel == {2'b00, ch_of(m_idx)}) begin
            m_en = 1;
            m_ch = ch_of(m_idx);
            m_x  = 10'(rsp_data >> (ADC_W - 10));
            exp_q.push_back({m_ch, m_x});
            if (m_idx == 0) begin m_phase = 1; m_idx = 1; end
            else m_phase = 0;
          end else begin
            m_w++;
            if (m_w >= TIMEOUT) begin m_set_to = 1; m_phase = 0; end
          end
        end
      endcase
      m_ov = m_set_ov || (m_ov && !clr_err);
      m_to = m_set_to || (m_to && !clr_err);
      m_cmd_valid = (m_phase == 1);
      m_cmd_ch    = (m_phase == 1) ? {2'b00, ch_of(m_idx)} : 5'd0;
    end
  end

  // ---------------- compare process + en log ----------------
  int en_cyc_q[$];
  logic [2:0] en_ch_q[$];
  logic [9:0] en_x_q[$];
  logic prev_en = 0;
  logic [12:0] got;

  always @(negedge clk) begin
    if (rstn) begin
      chk("cmd_valid", cmd_valid, m_cmd_valid);
      if (m_cmd_valid) chk("cmd_channel", cmd_channel, m_cmd_ch);
      chk("en", en, m_en);
      chk("channel", channel, m_ch);
      chk("X", X, m_x);
      chk("overrun", overrun, m_ov);
      chk("timeout_err", timeout_err, m_to);
      if (en) begin
        chk("en_not_back_to_back", prev_en, 0);
        chk("en_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          chk("en_sample", {channel, X}, got);
        end
        en_cyc_q.push_back(cyc);
        en_ch_q.push_back(channel);
        en_x_q.push_back(X);
      end
      prev_en = en;
    end else begin
      prev_en = 0;
    end
  end

  task automatic clear_log();
    en_cyc_q.delete();
    en_ch_q.delete();
    en_x_q.delete();
  endtask

  task automatic wait_en_ch(input logic [2:0] ch, input int budget, input string name);
    int n = 0;
    while (!(en && channel == ch) && n < budget) begin step(1); n++; end
    chk(name, n < budget, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_channel"}, cmd_channel, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_channel"}, channel, 0);
    chk({tag, "_X"}, X, 10'd512);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic release_and_time(input string name);
    int r0, n;
    run = 1; rstn = 1; r0 = cyc; n = 0;
    while (!cmd_valid && n < 4 * DIV) begin step(1); n++; end
    chk(name, cyc - r0 + 1, DIV + 1);
  endtask

  // ---------------- test sequence ----------------
  int hs0, n, q_en;
  initial begin
    step(3);
    check_reset_outputs("reset");
    release_and_time("first_cmd_cycle");

    // Nominal pairs with fixed data.
    clear_log();
    step(4 * DIV);
    chk("nom_en_count", en_ch_q.size() >= 4, 1);
    chk("nom_ch0", en_ch_q[0], CH_I);
    chk("nom_x0", en_x_q[0], 10'h280);
    chk("nom_ch1", en_ch_q[1], CH_Q);
    chk("nom_x1", en_x_q[1], 10'h0FF);
    chk("nom_period", en_cyc_q[2] - en_cyc_q[0], DIV);
    chk("nom_overrun", overrun, 0);
    chk("nom_timeout", timeout_err, 0);

    // Wrong-channel response ahead of each real one.
    wrong_first = 1;
    clear_log();
    step(2 * DIV);
    wrong_first = 0;
    chk("wrong_en_count", en_ch_q.size(), 4);
    foreach (en_ch_q[i]) begin
      if (en_ch_q[i] == CH_I) chk("wrong_x_i", en_x_q[i], 10'h280);
      else                    chk("wrong_x_q", en_x_q[i], 10'h0FF);
    end

    // Backpressure on the I command.
    wait_en_ch(CH_Q, 3 * DIV, "bp_sync");
    hold_ready = 1;
    n = 0;
    while (!cmd_valid && n < 3 * DIV) begin step(1); n++; end
    chk("bp_cmd_seen", n < 3 * DIV, 1);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_stable", cmd_valid, 1);
      chk("bp_channel_stable", cmd_channel, {2'b00, CH_I});
      step(1);
    end
    chk("bp_no_handshake", hs_cnt - hs0, 0);
    hold_ready = 0;
    wait_en_ch(CH_Q, 4 * DIV, "bp_pair_done");
    chk("bp_handshakes", hs_cnt - hs0, 2);
    clr_err = 1; step(1); clr_err = 0;

    // Timeout in WAIT_Q.
    wait_en_ch(CH_Q, 4 * DIV, "to_sync");
    dly_i = 1; drop_q = 1;
    wait_en_ch(CH_I, 4 * DIV, "to_i_emitted");
    clear_log();
    step(5);
    q_en = 0;
    foreach (en_ch_q[i]) if (en_ch_q[i] == CH_Q) q_en++;
    chk("to_no_q_en", q_en, 0);
    chk("to_flag", timeout_err, 1);
    chk("to_idle_no_cmd", cmd_valid, 0);
    drop_q = 0; dly_i = 2;
    clr_err = 1; step(1); clr_err = 0;
    chk("to_cleared", timeout_err, 0);
    chk("ov_clear_after_to", overrun, 0);
    wait_en_ch(CH_I, 3 * DIV, "to_fresh_i");
    wait_en_ch(CH_Q, 3 * DIV, "to_fresh_q");

    // Overrun: responses slow enough that the next tick lands mid-pair.
    dly_i = 3; dly_q = 3;
    n = 0;
    while (!overrun && n < 6 * DIV) begin step(1); n++; end
    chk("ov_set", overrun, 1);
    n = 0;
    while ((m_rate == DIV - 1 && m_phase != 0) && n < 4 * DIV) begin step(1); n++; end
    clr_err = 1; step(1); clr_err = 0;
    chk("ov_cleared", overrun, 0);
    n = 0;
    while (!overrun && n < 6 * DIV) begin step(1); n++; end
    chk("ov_set_again", overrun, 1);
    n = 0;
    while (!(run && m_rate == DIV - 1 && m_phase != 0) && n < 4 * DIV) begin step(1); n++; end
    chk("ov_tick_found", n < 4 * DIV, 1);
    clr_err = 1; step(1); clr_err = 0;
    chk("ov_set_beats_clear", overrun, 1);

    // Async reset while waiting for I.
    dly_i = 2; dly_q = 2;
    n = 0;
    while (!(cmd_valid && cmd_channel == {2'b00, CH_I}) && n < 4 * DIV) begin step(1); n++; end
    chk("rst_cmd_i_seen", n < 4 * DIV, 1);
    step(1);
    rstn = 0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    release_and_time("rst_first_cmd_cycle");

    // Randomized traffic.
    rand_ready = 1; rand_dly = 1; noise_en = 1; fixed_data = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) run = ~run;
      if ($urandom_range(0, 99) == 0)  drop_q = ~drop_q;
      clr_err = ($urandom_range(0, 29) == 0);
      step(1);
    end
    clr_err = 0; run = 1; drop_q = 0;
    step(2 * DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
